dbi_decode_16b: RTL and testbench

Receive-side data-bus-inversion decoder: accepts 17-bit DBI-encoded words (`{dbi_flag, payload}`) from the link driven by the DBI encoder and restores the original 16-bit data. Results go into a 2-entry output FIFO with valid/ready handshakes on both sides, so the downstream systolic-array input stage can apply backpressure. Optional link-activity counters report toggles, inverted words and word count, for power-efficiency measurement of the DBI scheme.

---
 rtl/dbi_decode_16b.sv | 125 ++++++++++++
 tb/tb_dbi_decode_16b.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/dbi_decode_16b.sv
// DBI receive-side decoder: restores the payload of {dbi_flag, payload} words and queues them in a 2-entry FIFO.
// Define DBI_DECODE_STATS_EN to build the link-activity counters (toggles, inverted words, word count).
module dbi_decode_16b #(
   parameter int unsigned bw    = 16,
   parameter int unsigned cnt_w = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   input  logic [bw:0]      in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [bw-1:0]    out_data,
   input  logic             out_ready,
   input  logic             stat_clr,
   output logic [cnt_w-1:0] toggle_cnt,
   output logic [cnt_w-1:0] inv_cnt,
   output logic [cnt_w-1:0] word_cnt
);

   localparam int unsigned DEPTH = 2;

   logic [bw-1:0] r_mem [DEPTH];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;

   logic          w_accept;
   logic          w_pop;
   logic [bw-1:0] w_payload;

   // Ready flags come from the registered occupancy only, so no ready path crosses the block.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign out_data  = r_mem[r_rd_ptr];

   assign w_accept  = in_valid && in_ready;
   assign w_pop     = out_valid && out_ready;
   assign w_payload = in_data[bw] ? ~in_data[bw-1:0] : in_data[bw-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_accept) begin
            r_mem[r_wr_ptr] <= w_payload;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         r_count <= r_count + 2'(w_accept) - 2'(w_pop);
      end
   end

`ifdef DBI_DECODE_STATS_EN
   localparam int unsigned PC_W  = $clog2(bw + 2);
   localparam int unsigned SUM_W = ((cnt_w > PC_W) ? cnt_w : PC_W) + 1;
   localparam logic [SUM_W-1:0] SAT_MAX = (SUM_W'(1) << cnt_w) - SUM_W'(1);

   logic [bw:0]      r_prev_bus;
   logic [cnt_w-1:0] r_toggle_cnt;
   logic [cnt_w-1:0] r_inv_cnt;
   logic [cnt_w-1:0] r_word_cnt;

   logic [bw:0]      w_diff;
   logic [PC_W-1:0]  w_toggles;

   // Widened add so a popcount larger than the counter range still clamps correctly.
   function automatic logic [cnt_w-1:0] sat_add(input logic [cnt_w-1:0] a,
                                                input logic [PC_W-1:0]  b);
      logic [SUM_W-1:0] s;
      s = SUM_W'(a) + SUM_W'(b);
      return (s > SAT_MAX) ? {cnt_w{1'b1}} : s[cnt_w-1:0];
   endfunction

   assign w_diff = in_data ^ r_prev_bus;

   always_comb begin
      w_toggles = '0;
      for (int unsigned i = 0; i < bw + 1; i++) begin
         w_toggles = w_toggles + PC_W'(w_diff[i]);
      end
   end

   // Clear wins over a same-cycle accept, but the link history still tracks that word.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev_bus   <= '0;
         r_toggle_cnt <= '0;
         r_inv_cnt    <= '0;
         r_word_cnt   <= '0;
      end else begin
         if (w_accept) begin
            r_prev_bus <= in_data;
         end
         if (stat_clr) begin
            r_toggle_cnt <= '0;
            r_inv_cnt    <= '0;
            r_word_cnt   <= '0;
         end else if (w_accept) begin
            r_toggle_cnt <= sat_add(r_toggle_cnt, w_toggles);
            r_inv_cnt    <= sat_add(r_inv_cnt, PC_W'(in_data[bw]));
            r_word_cnt   <= sat_add(r_word_cnt, PC_W'(1));
         end
      end
   end

   assign toggle_cnt = r_toggle_cnt;
   assign inv_cnt    = r_inv_cnt;
   assign word_cnt   = r_word_cnt;
`else
   logic w_unused_stat_clr;

   assign w_unused_stat_clr = stat_clr;
   assign toggle_cnt        = '0;
   assign inv_cnt           = '0;
   assign word_cnt          = '0;
`endif

endmodule

// File: tb/tb_dbi_decode_16b.sv
// Bench for dbi_decode_16b: queue-based reference model checked every cycle, plus directed literal checks.
// Two instances (cnt_w 16 and 4) share stimulus so counter saturation is exercised at both widths.
module tb_dbi_decode_16b;

`ifdef DBI_DECODE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic [16:0] in_data;
   logic        out_ready;
   logic        stat_clr;

   logic        in_ready,  out_valid;
   logic [15:0] out_data;
   logic [15:0] toggle_cnt, inv_cnt, word_cnt;

   logic        in_ready4, out_valid4;
   logic [15:0] out_data4;
   logic [3:0]  toggle_cnt4, inv_cnt4, word_cnt4;

   int n_checks = 0;
   int n_pass   = 0;

   dbi_decode_16b dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
      .out_ready(out_ready), .stat_clr(stat_clr),
      .toggle_cnt(toggle_cnt), .inv_cnt(inv_cnt), .word_cnt(word_cnt)
   );

   dbi_decode_16b #(.bw(16), .cnt_w(4)) dut4 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_ready(in_ready4), .out_valid(out_valid4), .out_data(out_data4),
      .out_ready(out_ready), .stat_clr(stat_clr),
      .toggle_cnt(toggle_cnt4), .inv_cnt(inv_cnt4), .word_cnt(word_cnt4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [31:0] sat(input longint v, input int w);
      longint mx;
      mx = (longint'(1) << w) - 1;
      return (v > mx) ? 32'(mx) : 32'(v);
   endfunction

   // Reference model: FIFO of original (pre-encoding) data, unsaturated counter totals.
   logic [15:0] q[$];
   logic [15:0] cur_raw;
   logic [16:0] m_prev;
   longint      m_tog, m_inv, m_word;
   bit          m_acc_last;

   always begin
      bit m_ready, acc, pop;
      @(posedge clk);
      m_ready = (q.size() != 2);
      acc     = in_valid && m_ready;
      pop     = (q.size() != 0) && out_ready;
      if (reset) begin
         q.delete();
         m_prev = '0; m_tog = 0; m_inv = 0; m_word = 0;
         m_acc_last = 1'b0;
      end else begin
         if (pop) void'(q.pop_front());
         if (acc) q.push_back(cur_raw);
         if (stat_clr) begin
            m_tog = 0; m_inv = 0; m_word = 0;
         end else if (acc) begin
            m_tog  += $countones(in_data ^ m_prev);
            m_inv  += longint'(in_data[16]);
            m_word += 1;
         end
         if (acc) m_prev = in_data;
         m_acc_last = acc;
      end
      #1;
      chk("in_ready",   32'(in_ready),   32'(q.size() != 2));
      chk("out_valid",  32'(out_valid),  32'(q.size() != 0));
      chk("in_ready4",  32'(in_ready4),  32'(q.size() != 2));
      chk("out_valid4", 32'(out_valid4), 32'(q.size() != 0));
      if (q.size() != 0) begin
         chk("out_data",  32'(out_data),  32'(q[0]));
         chk("out_data4", 32'(out_data4), 32'(q[0]));
      end
      chk("toggle_cnt",  32'(toggle_cnt),  STATS ? sat(m_tog, 16)  : 32'd0);
      chk("inv_cnt",     32'(inv_cnt),     STATS ? sat(m_inv, 16)  : 32'd0);
      chk("word_cnt",    32'(word_cnt),    STATS ? sat(m_word, 16) : 32'd0);
      chk("toggle_cnt4", 32'(toggle_cnt4), STATS ? sat(m_tog, 4)   : 32'd0);
      chk("inv_cnt4",    32'(inv_cnt4),    STATS ? sat(m_inv, 4)   : 32'd0);
      chk("word_cnt4",   32'(word_cnt4),   STATS ? sat(m_word, 4)  : 32'd0);
   end

   task automatic drive(input bit v, input bit f, input logic [15:0] raw);
      in_valid = v;
      cur_raw  = raw;
      in_data  = {f, f ? ~raw : raw};
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset    = 1'b1;
      @(negedge clk);
      reset    = 1'b0;
   endtask

   task automatic chk_counts(input string tag, input int t16, input int i16, input int w16,
                             input int t4, input int w4);
      chk({tag, "_tog"},  32'(toggle_cnt),  STATS ? 32'(t16) : 32'd0);
      chk({tag, "_inv"},  32'(inv_cnt),     STATS ? 32'(i16) : 32'd0);
      chk({tag, "_word"}, 32'(word_cnt),    STATS ? 32'(w16) : 32'd0);
      chk({tag, "_tog4"}, 32'(toggle_cnt4), STATS ? 32'(t4)  : 32'd0);
      chk({tag, "_wrd4"}, 32'(word_cnt4),   STATS ? 32'(w4)  : 32'd0);
   endtask

   initial begin
      logic [15:0] exp_seq [3];
      reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; stat_clr = 1'b0;
      cur_raw = '0;
      repeat (2) @(negedge clk);

      // Reset state
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk_counts("rst", 0, 0, 0, 0, 0);
      reset = 1'b0;

      // Basic decode: 1_00FF -> FF00, then 0_1234 -> 1234
      out_ready = 1'b1;
      drive(1'b1, 1'b1, 16'hFF00);
      chk("enc_00ff", 32'(in_data), 32'h1_00FF);
      @(negedge clk);
      chk("dec1_valid", 32'(out_valid), 32'd1);
      chk("dec1_data",  32'(out_data),  32'h0000_FF00);
      drive(1'b1, 1'b0, 16'h1234);
      @(negedge clk);
      chk("dec2_data",  32'(out_data),  32'h0000_1234);
      in_valid = 1'b0;
      @(negedge clk);

      // Counter arithmetic and saturation at cnt_w=4, then clear-with-accept
      do_reset();
      drive(1'b1, 1'b1, 16'h0000);          // 1_FFFF
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0000);          // 0_0000
      @(negedge clk);
      in_valid = 1'b0;
      chk_counts("st2", 34, 1, 2, 15, 2);
      drive(1'b1, 1'b1, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      chk_counts("st3", 51, 2, 3, 15, 3);
      drive(1'b1, 1'b1, 16'hFFFF);          // 1_0000 with clear
      stat_clr = 1'b1;
      @(negedge clk);
      stat_clr = 1'b0; in_valid = 1'b0;
      chk_counts("clr", 0, 0, 0, 0, 0);
      drive(1'b1, 1'b0, 16'h0000);
      @(negedge clk);
      in_valid = 1'b0;
      chk_counts("post", 1, 0, 1, 1, 1);
      @(negedge clk);

      // Backpressure: fill FIFO, hold third word, drain in order
      do_reset();
      out_ready = 1'b0;
      drive(1'b1, 1'b0, 16'h0001);
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h0002);
      @(negedge clk);
      chk("full_ready0", 32'(in_ready), 32'd0);
      drive(1'b1, 1'b0, 16'h0003);
      @(negedge clk);
      chk("held_ready0", 32'(in_ready), 32'd0);
      exp_seq[0] = 16'h0001; exp_seq[1] = 16'h0002; exp_seq[2] = 16'h0003;
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) in_valid = 1'b0;
         chk("drain_valid", 32'(out_valid), 32'd1);
         chk("drain_data",  32'(out_data),  32'(exp_seq[k]));
         @(negedge clk);
      end
      chk("drain_empty", 32'(out_valid), 32'd0);

      // Reset with FIFO full flushes everything
      out_ready = 1'b0;
      drive(1'b1, 1'b1, 16'hA5A5);
      @(negedge clk);
      drive(1'b1, 1'b0, 16'h5A5A);
      @(negedge clk);
      chk("pre_rst_full", 32'(in_ready), 32'd0);
      do_reset();
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_ready", 32'(in_ready),  32'd1);
      chk("mid_rst_data",  32'(out_data),  32'd0);
      chk_counts("mid_rst", 0, 0, 0, 0, 0);

      // 17 toggles per word drives the 16-bit counter into saturation
      out_ready = 1'b1;
      for (int i = 0; i < 5000; i++) begin
         drive(1'b1, (i % 2) == 0, 16'h0000);
         @(negedge clk);
      end
      in_valid = 1'b0;
      chk_counts("sat16", 65535, 2500, 5000, 15, 15);
      @(negedge clk);

      // Randomized traffic with backpressure, clears and occasional resets
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (!in_valid || m_acc_last) begin
            drive(($urandom % 4) != 0, 1'($urandom), 16'($urandom));
         end
         out_ready = ($urandom % 3) != 0;
         stat_clr  = ($urandom % 40) == 0;
         reset     = ($urandom % 400) == 0;
         @(negedge clk);
      end
      reset = 1'b0; in_valid = 1'b0; stat_clr = 1'b0;
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
